// File: rtl/data_sram_resp_pkg.sv
// Shared types and default parameters for the data-SRAM response model.
// The queue entry is packed as {op, wstrb, word address, wdata}.
package data_sram_resp_pkg;

  localparam int MEM_AW_DEF = 10;
  localparam int QDEPTH_DEF = 4;
  localparam int DELAY_DEF  = 2;

  localparam int ENT_OP_W   = 1;
  localparam int ENT_STRB_W = 4;
  localparam int ENT_DATA_W = 32;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic int entry_width(input int mem_aw);
    return ENT_OP_W + ENT_STRB_W + mem_aw + ENT_DATA_W;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Request/response bus of the data SRAM port.
// The master is the requester; the slave is the SRAM response model.
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_resp_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so the pointers wrap freely.
// Only the pointers and count are reset; slot contents are don't-care when empty.
module sram_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = slot_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) slot_q[wr_ptr_q] <= din;
  end

  a_count_bounded: assert property (@(posedge clk) disable iff (reset)
    count_q <= CW'(DEPTH));

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM response model: queues accepted requests, answers them in order
// DELAY cycles after each reaches the head, and commits writes at response time.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int QDEPTH = QDEPTH_DEF,
  parameter int DELAY  = DELAY_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  data_sram_if.slave                data_sram,
  input  logic                      resp_hold,
  output logic [$clog2(QDEPTH):0]   outstanding
);

  localparam int ENT_W    = entry_width(MEM_AW);
  localparam int WORD_LSB = ENT_DATA_W;
  localparam int STRB_LSB = WORD_LSB + MEM_AW;
  localparam int OP_BIT   = STRB_LSB + ENT_STRB_W;
  localparam int CNT_W    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  logic [ENT_W-1:0]      push_ent, head_ent;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  op_e                   head_op;
  logic [ENT_STRB_W-1:0] head_wstrb;
  logic [MEM_AW-1:0]     head_word;
  logic [ENT_DATA_W-1:0] head_wdata;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           mem_q [2**MEM_AW];
  logic                  data_ok;

  // size and the address bits outside the word index do not affect storage
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram.size, data_sram.addr[31:MEM_AW+2], data_sram.addr[1:0]};

  assign data_sram.addr_ok = ~fifo_full;
  assign push     = data_sram.req & ~fifo_full;
  assign push_ent = {data_sram.wr, data_sram.wstrb, data_sram.addr[MEM_AW+1:2], data_sram.wdata};

  sram_req_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_ent),
    .dout  (head_ent),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  assign head_op    = op_e'(head_ent[OP_BIT]);
  assign head_wstrb = head_ent[OP_BIT-1:STRB_LSB];
  assign head_word  = head_ent[STRB_LSB-1:WORD_LSB];
  assign head_wdata = head_ent[WORD_LSB-1:0];

  assign data_ok = ~fifo_empty & ~resp_hold & (cnt_q == CNT_LAST);
  assign pop     = data_ok;

  // The timer saturates at DELAY-1 so a held head responds on the first unheld cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (pop || fifo_empty) begin
      cnt_d = '0;
    end else if (!resp_hold && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (data_ok && (head_op == OP_WRITE)) begin
      for (int b = 0; b < ENT_STRB_W; b++) begin
        if (head_wstrb[b]) mem_q[head_word][8*b +: 8] <= head_wdata[8*b +: 8];
      end
    end
  end

  assign data_sram.data_ok = data_ok;
  assign data_sram.rdata   = (data_ok && (head_op == OP_READ)) ? mem_q[head_word] : 32'h0;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: DELAY=2 and DELAY=1 instances share stimulus and are
// each compared every cycle against a queue-based model of the response rules.
module tb_data_sram_resp;
  import data_sram_resp_pkg::*;

  localparam int QD = 4;
  localparam int AW = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic [2:0] outst_a, outst_b;

  always #5 clk = ~clk;

  data_sram_if bus_a ();
  data_sram_if bus_b ();

  data_sram_resp #(.MEM_AW(AW), .QDEPTH(QD), .DELAY(2)) dut_a (
    .clk(clk), .reset(reset), .data_sram(bus_a), .resp_hold(hold), .outstanding(outst_a));

  data_sram_resp #(.MEM_AW(AW), .QDEPTH(QD), .DELAY(1)) dut_b (
    .clk(clk), .reset(reset), .data_sram(bus_b), .resp_hold(hold), .outstanding(outst_b));

  typedef struct {
    bit        wr;
    bit [3:0]  strb;
    int        word;
    bit [31:0] data;
  } ent_t;

  ent_t      mq [2][$];
  int        waited [2];
  bit [31:0] mmem [2][1024];
  bit        mknown [2][1024];
  int        log_cyc [2][$];
  bit [31:0] log_rd [2][$];
  bit [31:0] fillval [16];
  string     nm [2] = '{"a", "b"};
  int        cyc;
  int        n_checks;
  int        n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int dly(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic bit [31:0] waddr(input int w);
    bit [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_F000) | (32'(w) << 2) | (r & 32'h3);
  endfunction

  task automatic drive(input bit req, input bit wr, input bit [3:0] strb,
                       input bit [31:0] addr, input bit [31:0] wdata);
    bit [1:0] sz;
    sz = 2'($urandom);
    bus_a.req = req; bus_a.wr = wr; bus_a.size = sz; bus_a.wstrb = strb;
    bus_a.addr = addr; bus_a.wdata = wdata;
    bus_b.req = req; bus_b.wr = wr; bus_b.size = sz; bus_b.wstrb = strb;
    bus_b.addr = addr; bus_b.wdata = wdata;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      waited[i] = 0;
    end
  endtask

  // One clock cycle: drive, check both instances at negedge, advance the model.
  task automatic step(input bit req, input bit wr, input bit [3:0] strb,
                      input bit [31:0] addr, input bit [31:0] wdata,
                      input bit h, output bit acc_a);
    bit          exp_dok [2];
    bit          acc [2];
    logic        aok, dok;
    logic [31:0] rd;
    logic [2:0]  os;
    bit [31:0]   exp_rd;
    bit          rd_known;
    ent_t        e;
    drive(req, wr, strb, addr, wdata);
    hold = h;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      aok = (i == 0) ? bus_a.addr_ok : bus_b.addr_ok;
      dok = (i == 0) ? bus_a.data_ok : bus_b.data_ok;
      rd  = (i == 0) ? bus_a.rdata   : bus_b.rdata;
      os  = (i == 0) ? outst_a       : outst_b;
      exp_dok[i] = 1'b0;
      exp_rd     = 32'h0;
      rd_known   = 1'b1;
      if (mq[i].size() > 0) begin
        exp_dok[i] = !h && (waited[i] == dly(i) - 1);
        if (exp_dok[i] && !mq[i][0].wr) begin
          exp_rd   = mmem[i][mq[i][0].word];
          rd_known = mknown[i][mq[i][0].word];
        end
      end
      check({nm[i], ".addr_ok"}, 32'(aok), 32'(mq[i].size() < QD));
      check({nm[i], ".data_ok"}, 32'(dok), 32'(exp_dok[i]));
      check({nm[i], ".outstanding"}, 32'(os), mq[i].size());
      if (rd_known) check({nm[i], ".rdata"}, rd, exp_rd);
      if (dok === 1'b1) begin
        log_cyc[i].push_back(cyc);
        log_rd[i].push_back(rd);
      end
      acc[i] = req && (mq[i].size() < QD);
    end
    acc_a = acc[0];
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (exp_dok[i]) begin
        e = mq[i].pop_front();
        if (e.wr) begin
          for (int b = 0; b < 4; b++)
            if (e.strb[b]) mmem[i][e.word][8*b +: 8] = e.data[8*b +: 8];
          if (e.strb == 4'hF) mknown[i][e.word] = 1'b1;
        end
        waited[i] = 0;
      end else if (mq[i].size() == 0) begin
        waited[i] = 0;
      end else if (!h && (waited[i] < dly(i) - 1)) begin
        waited[i]++;
      end
      if (acc[i]) begin
        e.wr = wr; e.strb = strb; e.word = int'(addr[AW+1:2]); e.data = wdata;
        mq[i].push_back(e);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit h);
    bit a;
    repeat (n) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, h, a);
  endtask

  task automatic send(input bit wr, input bit [3:0] strb, input bit [31:0] addr,
                      input bit [31:0] wdata, input string tag);
    bit a;
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) step(1'b1, wr, strb, addr, wdata, 1'b0, a);
    check({tag, ".accepted"}, 32'(a), 32'h1);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      log_cyc[i].delete();
      log_rd[i].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit a;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    hold     = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    model_reset();
    #1;
    check("rst.addr_ok", 32'(bus_a.addr_ok), 32'h1);
    check("rst.data_ok", 32'(bus_a.data_ok), 32'h0);
    check("rst.rdata", bus_a.rdata, 32'h0);
    check("rst.outstanding", 32'(outst_b), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int w = 0; w < 16; w++) begin
      fillval[w] = $urandom;
      send(1'b1, 4'hF, waddr(w), fillval[w], "fill");
    end
    idle(10, 1'b0);

    // write then read the same word, DELAY=2 latencies
    clear_logs();
    t0 = cyc;
    step(1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEADBEEF, 1'b0, a);
    step(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0, 1'b0, a);
    idle(6, 1'b0);
    check("wr_rd.count", log_cyc[0].size(), 2);
    if (log_cyc[0].size() >= 2) begin
      check("wr_rd.wlat", log_cyc[0][0] - t0, 2);
      check("wr_rd.rlat", log_cyc[0][1] - t0, 4);
      check("wr_rd.rdata", log_rd[0][1], 32'hDEADBEEF);
    end

    // partial byte-lane write
    clear_logs();
    step(1'b1, 1'b1, 4'hF, 32'h2000, 32'h11223344, 1'b0, a);
    step(1'b1, 1'b1, 4'h2, 32'h2000, 32'h0000AB00, 1'b0, a);
    step(1'b1, 1'b0, 4'h0, 32'h2000, 32'h0, 1'b0, a);
    idle(8, 1'b0);
    check("strb.count_a", log_rd[0].size(), 3);
    check("strb.count_b", log_rd[1].size(), 3);
    if (log_rd[0].size() >= 3) check("strb.rdata_a", log_rd[0][2], 32'h1122AB44);
    if (log_rd[1].size() >= 3) check("strb.rdata_b", log_rd[1][2], 32'h1122AB44);

    // fill the queue under hold, then release
    clear_logs();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'h0, waddr(1 + k), 32'h0, 1'b1, a);
    check("full.outstanding", 32'(outst_a), 32'h4);
    check("full.addr_ok", 32'(bus_a.addr_ok), 32'h0);
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) step(1'b1, 1'b0, 4'h0, waddr(5), 32'h0, 1'b0, a);
    check("full.fifth_accepted", 32'(a), 32'h1);
    idle(12, 1'b0);
    check("full.count", log_rd[0].size(), 5);
    for (int k = 0; k < 5 && k < log_rd[0].size(); k++)
      check($sformatf("full.order%0d", k), log_rd[0][k], fillval[1 + k]);

    // DELAY=1 instance: one response per cycle
    clear_logs();
    t0 = cyc;
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 4'h0, waddr(8 + k), 32'h0, 1'b0, a);
    idle(12, 1'b0);
    check("d1.count", log_cyc[1].size(), 8);
    for (int k = 0; k < 8 && k < log_cyc[1].size(); k++) begin
      check($sformatf("d1.cyc%0d", k), log_cyc[1][k] - t0, 1 + k);
      check($sformatf("d1.rdata%0d", k), log_rd[1][k], fillval[8 + k]);
    end

    // hold pulsed while head is due
    clear_logs();
    t0 = cyc;
    step(1'b1, 1'b0, 4'h0, waddr(5), 32'h0, 1'b0, a);
    idle(1, 1'b0);
    idle(3, 1'b1);
    idle(6, 1'b0);
    check("hold.count", log_cyc[0].size(), 1);
    if (log_cyc[0].size() >= 1) begin
      check("hold.lat", log_cyc[0][0] - t0, 5);
      check("hold.rdata", log_rd[0][0], fillval[5]);
    end
    if (log_cyc[1].size() >= 1) check("hold.lat_b", log_cyc[1][0] - t0, 1);

    // reset with requests in flight and a response due this cycle
    clear_logs();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'h0, waddr(2 + k), 32'h0, 1'b1, a);
    idle(1, 1'b0);
    check("rstmid.outstanding_pre", 32'(outst_a), 32'h3);
    check("rstmid.data_ok_pre", 32'(bus_a.data_ok), 32'h1);
    reset = 1'b1;
    #1;
    model_reset();
    check("rstmid.addr_ok", 32'(bus_a.addr_ok), 32'h1);
    check("rstmid.data_ok", 32'(bus_a.data_ok), 32'h0);
    check("rstmid.rdata", bus_a.rdata, 32'h0);
    check("rstmid.outstanding", 32'(outst_a), 32'h0);
    check("rstmid.outstanding_b", 32'(outst_b), 32'h0);
    clear_logs();
    idle(2, 1'b0);
    reset = 1'b0;
    idle(8, 1'b0);
    check("rstmid.no_resp_a", log_cyc[0].size(), 0);
    check("rstmid.no_resp_b", log_cyc[1].size(), 0);
    clear_logs();
    step(1'b1, 1'b0, 4'h0, 32'h2000, 32'h0, 1'b0, a);
    idle(4, 1'b0);
    if (log_rd[0].size() >= 1) check("rstmid.kept", log_rd[0][0], 32'h1122AB44);
    else check("rstmid.kept_count", log_rd[0].size(), 1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 3) != 0, $urandom % 2, 4'($urandom), waddr($urandom % 16),
           $urandom, ($urandom % 8) == 0, a);
    end
    idle(12, 1'b0);
    check("final.outstanding_a", 32'(outst_a), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, word-address width (2^MEM_AW 32-bit words of storage).
REQ-002 SHALL have parameter QDEPTH, default 4, request-queue depth (power of two, >=2).
REQ-003 SHALL have parameter DELAY, default 2, cycles from a request becoming queue head to its data_ok (>=1).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_sram_req  in  1  request valid.
REQ-007 SHALL have port data_sram_wr  in  1  1=write, 0=read.
REQ-008 SHALL have port data_sram_size  in  2  access size; carried, not used for storage.
REQ-009 SHALL have port data_sram_wstrb  in  4  byte-lane write enables.
REQ-010 SHALL have port data_sram_addr  in  32  byte address.
REQ-011 SHALL have port data_sram_wdata  in  32  write data.
REQ-012 SHALL have port data_sram_addr_ok  out  1  request accepted this cycle when data_sram_req also high.
REQ-013 SHALL have port data_sram_data_ok  out  1  one-cycle response pulse, one per accepted request.
REQ-014 SHALL have port data_sram_rdata  out  32  read data, valid only with data_ok of a read.
REQ-015 SHALL have port resp_hold  in  1  bench stall control; freezes response timer.
REQ-016 SHALL have port outstanding  out  $clog2(QDEPTH)+1  accepted-but-unanswered request count.

Function
REQ-017 SHALL assert addr_ok = (outstanding < QDEPTH), independent of req and of a same-cycle pop (no full-queue bypass).
REQ-018 SHALL push {wr, wstrb, addr[MEM_AW+1:2], wdata} into the FIFO on req & addr_ok; addr[1:0] and addr[31:MEM_AW+2] ignored.
REQ-019 SHALL keep a head timer cnt: cleared on pop or when queue empty; else increments each cycle head valid, resp_hold low, cnt < DELAY-1.
REQ-020 SHALL drive data_ok = head_valid & ~resp_hold & (cnt == DELAY-1); data_ok pops the head at that edge.
REQ-021 SHALL give latency: request accepted in cycle T into empty queue, data_ok in cycle T+DELAY (no resp_hold).
REQ-022 SHALL, for successive entries, issue next data_ok DELAY cycles after previous data_ok; DELAY=1 yields one response per cycle.
REQ-023 SHALL return responses strictly in acceptance order.
REQ-024 SHALL drive rdata = storage[head word] combinationally when data_ok and head is a read, else 32'h0.
REQ-025 SHALL write head wdata byte lanes selected by wstrb into storage at the edge ending its data_ok cycle; wstrb=0 writes nothing.
REQ-026 SHALL make a read see all earlier-accepted writes (follows from in-order, write-at-response).
REQ-027 SHALL update outstanding by +push -pop; simultaneous push and pop leaves it unchanged.
REQ-028 SHALL never drop an accepted request; no cancel input (requester discards unwanted data).

Reset
REQ-029 SHALL on reset clear FIFO pointers, outstanding, cnt; addr_ok=1, data_ok=0, rdata=0 immediately.
REQ-030 SHALL discard all in-flight requests on reset mid-operation; no data_ok for them after release.
REQ-031 SHALL NOT reset storage contents; pending writes not yet answered are lost.

Structure
REQ-032 SHALL place default MEM_AW, QDEPTH, DELAY and the queue-entry field widths in the shared pipeline package.
REQ-033 SHALL implement the queue as sub-module sram_req_fifo (synchronous FIFO, push/pop/full/empty/count).

Verification
REQ-034 Write 0x1000 data 0xDEADBEEF wstrb 0xF, then read 0x1000 -> data_ok at T+2 and T+4 (DELAY=2), rdata 0xDEADBEEF.
REQ-035 Write 0x2000 wstrb 0x2 data 0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.
REQ-036 5 back-to-back reqs, QDEPTH=4, resp_hold=1 -> addr_ok low on 5th, outstanding=4; release -> 4 data_ok in order, 5th then accepted.
REQ-037 DELAY=1, 8 consecutive reads -> data_ok every cycle starting T+1, addresses in order.
REQ-038 Assert reset with outstanding=3 -> outputs reset same cycle; no data_ok after release; prior completed write still readable.
REQ-039 resp_hold pulsed 3 cycles at cnt=DELAY-1 -> data_ok delayed exactly 3 cycles, rdata unchanged.
